// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - aluCtr codes, mult/div FSM states and op classification for alu_md
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MULT  = 4'b1010;
    localparam logic [3:0] ALU_MULTU = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_DIV   = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_RSVD  = 4'b1111;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_t;

    function automatic logic is_md(input logic [3:0] ctr);
        return (ctr == ALU_MULT) || (ctr == ALU_MULTU) ||
               (ctr == ALU_DIV)  || (ctr == ALU_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative shift-add multiplier / restoring divider on magnitudes
module md_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             fin,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   acc_q, q_q, m_q, a_raw_q;
    logic               div_op_q, neg_lo_q, neg_hi_q, div0_q;
    logic               a_neg, b_neg, last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] prod;

    assign a_neg    = op_signed & a[WIDTH-1];
    assign b_neg    = op_signed & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign div_sh   = {acc_q, q_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    assign last     = (cnt_q == CW'(WIDTH - 1));
    assign idle     = (state_q == MD_IDLE);
    assign fin      = (state_q == MD_FIX);

    always_ff @(posedge clk) begin
        if (reset) state_q <= MD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = op_div ? MD_DIV : MD_MUL;
            MD_MUL,
            MD_DIV:  if (last) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // acc holds the upper product / partial remainder, q the lower product / quotient
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            a_raw_q  <= '0;
            div_op_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: if (start) begin
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    q_q      <= a_mag;
                    m_q      <= b_mag;
                    a_raw_q  <= a;
                    div_op_q <= op_div;
                    neg_lo_q <= a_neg ^ b_neg;
                    neg_hi_q <= a_neg;
                    div0_q   <= op_div && (b == '0);
                end
                MD_MUL: begin
                    acc_q <= mul_sum[WIDTH:1];
                    q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                MD_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_q <= div_diff[WIDTH-1:0];
                        q_q   <= {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_q <= div_sh[WIDTH-1:0];
                        q_q   <= {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign prod = neg_lo_q ? -{acc_q, q_q} : {acc_q, q_q};

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_op_q) begin
            if (div0_q) begin
                res_hi = a_raw_q;
                res_lo = '1;
            end else begin
                res_hi = neg_hi_q ? -acc_q : acc_q;
                res_lo = neg_lo_q ? -q_q : q_q;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - registered EX-stage ALU with iterative mult/div into HI/LO
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [3:0]       aluCtr,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] aluRes,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accept, md_start, md_idle, md_fin, op_div, op_signed, sc_ovf;
    logic [WIDTH-1:0] md_hi, md_lo, sc_res, sum, diff;
    logic [SHW-1:0]   shamt;

    assign ready     = md_idle;
    assign accept    = start && ready;
    assign md_start  = accept && is_md(aluCtr);
    assign op_div    = (aluCtr == ALU_DIV) || (aluCtr == ALU_DIVU);
    assign op_signed = (aluCtr == ALU_MULT) || (aluCtr == ALU_DIV);
    assign sum       = input1 + input2;
    assign diff      = input1 - input2;
    assign shamt     = input1[SHW-1:0];

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .reset     (reset),
        .start     (md_start),
        .op_div    (op_div),
        .op_signed (op_signed),
        .a         (input1),
        .b         (input2),
        .idle      (md_idle),
        .fin       (md_fin),
        .res_hi    (md_hi),
        .res_lo    (md_lo)
    );

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (aluCtr)
            ALU_AND:  sc_res = input1 & input2;
            ALU_OR:   sc_res = input1 | input2;
            ALU_XOR:  sc_res = input1 ^ input2;
            ALU_NOR:  sc_res = ~(input1 | input2);
            ALU_ADD: begin
                sc_res = sum;
                sc_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_res = diff;
                sc_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(input1) < $signed(input2)};
            ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, input1 < input2};
            ALU_SLL:  sc_res = input2 << shamt;
            ALU_SRL:  sc_res = input2 >> shamt;
            ALU_SRA:  sc_res = $signed(input2) >>> shamt;
            ALU_RSVD: sc_res = '0;
            default:  sc_res = '0;
        endcase
    end

    // a single-cycle accept and md_fin never coincide: ready is low throughout FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            aluRes   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (accept && !is_md(aluCtr)) begin
                done     <= 1'b1;
                aluRes   <= sc_res;
                zero     <= (sc_res == '0);
                overflow <= sc_ovf;
            end else if (md_fin) begin
                done     <= 1'b1;
                aluRes   <= md_lo;
                zero     <= (md_lo == '0);
                overflow <= 1'b0;
                hi       <= md_hi;
                lo       <= md_lo;
            end
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb/tb_alu_md.sv - directed self-checking bench for alu_md
module tb_alu_md;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, ready, done, zero, overflow;
    logic [W-1:0] input1, input2, aluRes, hi, lo;
    logic [3:0]   aluCtr;
    int           errors = 0;
    int           checks = 0;
    int           dn;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .input1   (input1),
        .input2   (input2),
        .aluCtr   (aluCtr),
        .ready    (ready),
        .done     (done),
        .aluRes   (aluRes),
        .zero     (zero),
        .overflow (overflow),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ctr, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        aluCtr = ctr;
        input1 = a;
        input2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sc(input string tag, input logic [3:0] ctr, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp, input logic exp_ovf);
        issue(ctr, a, b);
        check({tag, "_done"}, done, 1);
        check({tag, "_res"}, aluRes, exp);
        check({tag, "_zero"}, zero, exp == '0);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic md(input string tag, input logic [3:0] ctr, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                      input logic [W-1:0] exp_lo, input bit inject);
        int lat, rl;
        lat = 1;
        rl  = 0;
        issue(ctr, a, b);
        while (!done && lat < 60) begin
            if (!ready) rl++;
            if (inject && lat == 5) begin
                start  = 1'b1;
                aluCtr = ALU_MULTU;
                input1 = '1;
                input2 = 2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, W + 2);
        check({tag, "_ready_low"}, rl, W + 1);
        check({tag, "_ready_at_done"}, ready, 1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_res"}, aluRes, exp_lo);
        check({tag, "_zero"}, zero, exp_lo == '0);
        check({tag, "_ovf"}, overflow, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle_after"}, ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        aluCtr = ALU_AND;
        input1 = '0;
        input2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_res", aluRes, 0);
        check("rst_zero", zero, 1);
        check("rst_ovf", overflow, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        sc("and",      ALU_AND,  255, 170, 170, 0);
        sc("or",       ALU_OR,   255, 170, 255, 0);
        sc("add",      ALU_ADD,  1, 1, 2, 0);
        sc("sub_zero", ALU_SUB,  1, 1, 0, 0);
        sc("sub",      ALU_SUB,  255, 170, 85, 0);
        sc("xor",      ALU_XOR,  255, 170, 32'h55, 0);
        sc("slt_0",    ALU_SLT,  250, 170, 0, 0);
        sc("slt_1",    ALU_SLT,  170, 255, 1, 0);
        sc("sltu",     ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 0);
        sc("slt_neg",  ALU_SLT,  32'hFFFF_FFFF, 1, 1, 0);
        sc("nor",      ALU_NOR,  32'h8000_0001, 32'h8000_0002, 32'h7FFF_FFFC, 0);
        sc("add_ovf",  ALU_ADD,  32'h7FFF_FFFF, 1, 32'h8000_0000, 1);
        sc("sub_ovf",  ALU_SUB,  32'h8000_0000, 1, 32'h7FFF_FFFF, 1);
        sc("sra",      ALU_SRA,  4, 32'h8000_0000, 32'hF800_0000, 0);
        sc("srl",      ALU_SRL,  4, 32'h8000_0000, 32'h0800_0000, 0);
        sc("sll_mask", ALU_SLL,  32'h24, 1, 16, 0);
        sc("rsvd",     ALU_RSVD, 5, 6, 0, 0);

        @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("hold_res", aluRes, 0);
        check("hold_hi", hi, 0);

        dn = 0;
        issue(ALU_ADD, 10, 20);  dn += int'(done); check("b2b_1", aluRes, 30);
        issue(ALU_SUB, 10, 20);  dn += int'(done); check("b2b_2", aluRes, 32'hFFFF_FFF6);
        issue(ALU_OR,  12, 3);   dn += int'(done); check("b2b_3", aluRes, 15);
        issue(ALU_AND, 12, 6);   dn += int'(done); check("b2b_4", aluRes, 4);
        check("b2b_count", dn, 4);

        md("mult",     ALU_MULT,  32'hFFFF_FFFD, 7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        md("multu",    ALU_MULTU, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE, 0);
        md("div",      ALU_DIV,   32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        md("div_nd",   ALU_DIV,   7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 0);
        md("divu_z",   ALU_DIVU,  7, 0, 7, 32'hFFFF_FFFF, 0);
        md("div_min",  ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0);
        md("divu_q0",  ALU_DIVU,  3, 7, 3, 0, 0);
        md("div_busy", ALU_DIV,   100, 7, 2, 14, 1);

        issue(ALU_MULTU, 32'hFFFF_FFFF, 2);
        repeat (9) @(posedge clk);
        #1;
        check("pre_rst_busy", ready, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            dn += int'(done);
            @(posedge clk);
            #1;
        end
        check("abort_no_done", dn, 0);
        sc("post_rst_add", ALU_ADD, 2, 3, 5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised, registered successor of the 32-bit single-cycle ALU.
- Keeps the existing aluCtr encoding and adds XOR, shifts, unsigned compare, overflow detection, and iterative multiply/divide into HI/LO registers.
- Sits in the EX stage of the multi-cycle MIPS datapath.
- Uses a start/ready/done handshake so the control FSM can stall on mult/div.

Parameters:
- WIDTH, 32, operand/result width; must be even and ≥ 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from input1[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted when start && ready.
- input1  input  WIDTH  operand A (shift amount for shifts).
- input2  input  WIDTH  operand B (value shifted for shifts).
- aluCtr  input  4  operation select.
- ready  output  1  high when idle and able to accept.
- done  output  1  one-cycle pulse when aluRes/flags/hi/lo are updated.
- aluRes  output  WIDTH  registered result.
- zero  output  1  registered (aluRes == 0).
- overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.
- hi  output  WIDTH  HI register (remainder / upper product).
- lo  output  WIDTH  LO register (quotient / lower product).

Behaviour:
- Reset: ready=1, done=0, aluRes=0, zero=1, overflow=0, hi=0, lo=0, FSM=IDLE.
- Reset mid-operation aborts the operation; no done pulse; the partial result is discarded.
- aluCtr encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL.
  - 0110 SUB, 0111 SLT (signed), 1000 SRA, 1001 SLTU.
  - 1010 MULT, 1011 MULTU, 1100 NOR, 1101 DIV, 1110 DIVU.
  - 1111 reserved: result 0, done pulses.
- Single-cycle ops (everything except 1010/1011/1101/1110):
  - Accepted in cycle N; aluRes, zero and overflow are registered at the edge ending cycle N; done=1 in cycle N+1.
  - ready stays 1, so back-to-back issue gives one result per cycle.
  - hi/lo unchanged.
- Width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or different (SUB) and result sign differs from input1.
  - SLT/SLTU give 1 or 0 zero-extended.
  - Shifts use input1[SHW-1:0] only.
- Mult/div FSM: IDLE -> MUL or DIV -> FIX -> IDLE.
  - Accept cycle N: operands are latched, converted to magnitudes when signed, sign flags saved; ready=0 from cycle N+1.
  - MUL: radix-2 shift-add, WIDTH iterations, one per cycle.
  - DIV: restoring division, WIDTH iterations, one per cycle.
  - FIX: one cycle of sign correction, then hi/lo and aluRes=lo are written.
  - done pulses exactly WIDTH+2 cycles after accept (cycle N+WIDTH+2); ready returns to 1 in the same cycle.
  - zero reflects lo; overflow=0.
- Signed division: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (DIV/DIVU): lo = all ones, hi = input1; full latency still applies.
- Signed MIN / -1: lo = MIN, hi = 0.
- start while ready=0 is ignored (no queueing); aluCtr and operands are don't-care while busy.
- aluRes/zero/overflow hold their values between done pulses.

Decomposition:
- Package alu_pkg:
  - localparams for the 16 aluCtr codes.
  - FSM state encoding (IDLE, MUL, DIV, FIX).
  - function is_md(aluCtr).
- Sub-module md_unit:
  - Iterative multiply/divide datapath plus counter, with start/done.
  - alu_md instantiates it and owns the single-cycle datapath and output registers.

Test Plan:
- Single-cycle ops (WIDTH=32): AND 255&170 -> aluRes=170, zero=0; OR -> 255; ADD 1+1 -> 2; SUB 1-1 -> 0, zero=1; SUB 255-170 -> 85.
- Compare and NOR:
  - SLT 250,170 -> 0; SLT 170,255 -> 1.
  - SLTU 0xFFFFFFFF,1 -> 0; SLT same operands -> 1.
  - NOR 0x80000001,0x80000002 -> 0x7FFFFFFC.
- ADD overflow and shifts:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SRA by 4 of 0x80000000 -> 0xF8000000.
  - Back-to-back issue over 4 consecutive cycles -> 4 consecutive done pulses.
- MULT and MULTU:
  - MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done at exactly accept+34; ready low for 33 cycles.
  - MULTU 0xFFFFFFFF × 2 -> hi=1, lo=0xFFFFFFFE.
- DIV cases:
  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
  - DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Busy and reset:
  - start pulsed during DIV busy -> ignored, hi/lo reflect the DIV only.
  - reset at accept+10 -> ready=1, hi=lo=0 next cycle, no done pulse.
